// File: rtl/carus_clk_gate_ctrl.sv
// Automatic clock-gating controller for the Carus accelerator, running in the always-on domain.
// It gates the Carus clock after a programmable idle period and restores it on a level wake handshake.
module carus_clk_gate_ctrl #(
  parameter int unsigned IDLE_CNT_W  = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned EVT_CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  auto_en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  input  logic                  busy_i,
  input  logic                  wake_req_i,
  output logic                  wake_ack_o,
  output logic                  clk_en_o,
  output logic                  gated_o,
  output logic [1:0]            state_o,
  output logic [EVT_CNT_W-1:0]  evt_cnt_o,
  input  logic                  evt_clr_i
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_IDLE_WAIT = 2'd1;
  localparam logic [1:0] ST_GATED     = 2'd2;
  localparam logic [1:0] ST_WAKE      = 2'd3;

  localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_d;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;
  logic [IDLE_CNT_W-1:0] w_idle_cnt_d;
  logic [WAKE_W-1:0]     r_wake_cnt;
  logic [WAKE_W-1:0]     w_wake_cnt_d;
  logic                  r_ack;
  logic                  w_ack_d;
  logic                  r_clk_en;
  logic                  r_gated;
  logic [EVT_CNT_W-1:0]  r_evt_cnt;
  logic                  w_evt_inc;
  logic                  w_idle;

  assign w_idle = auto_en_i & ~busy_i & ~wake_req_i;

  always_comb begin
    w_state_d    = r_state;
    w_idle_cnt_d = r_idle_cnt;
    w_wake_cnt_d = r_wake_cnt;
    w_ack_d      = 1'b0;
    w_evt_inc    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_ack_d = wake_req_i;
        if (w_idle) begin
          w_state_d    = ST_IDLE_WAIT;
          w_idle_cnt_d = '0;
        end
      end
      ST_IDLE_WAIT: begin
        w_ack_d = wake_req_i;
        if (!w_idle) begin
          w_state_d    = ST_RUN;
          w_idle_cnt_d = '0;
        end else if (r_idle_cnt == idle_thresh_i) begin
          w_state_d = ST_GATED;
          w_evt_inc = 1'b1;
        end else begin
          // Free-running wrap guarantees a later match if the threshold drops below the count.
          w_idle_cnt_d = r_idle_cnt + 1'b1;
        end
      end
      ST_GATED: begin
        if (wake_req_i || !auto_en_i) begin
          w_state_d    = ST_WAKE;
          w_wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        w_wake_cnt_d = r_wake_cnt + 1'b1;
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_d = ST_RUN;
        end
      end
      default: begin
        w_state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_ack      <= 1'b0;
      r_clk_en   <= 1'b1;
      r_gated    <= 1'b0;
      r_evt_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_wake_cnt <= w_wake_cnt_d;
      r_ack      <= w_ack_d;
      r_clk_en   <= (w_state_d != ST_GATED);
      r_gated    <= (w_state_d == ST_GATED);
      if (evt_clr_i) begin
        r_evt_cnt <= '0;
      end else if (w_evt_inc && (r_evt_cnt != {EVT_CNT_W{1'b1}})) begin
        r_evt_cnt <= r_evt_cnt + 1'b1;
      end
    end
  end

  assign wake_ack_o = r_ack;
  assign clk_en_o   = r_clk_en;
  assign gated_o    = r_gated;
  assign state_o    = r_state;
  assign evt_cnt_o  = r_evt_cnt;

endmodule
